// File: rtl/rtan_pkg.sv
// Shared types and tan coefficient tables for the r*tan(theta) pipeline.
// Coefficients are round-to-nearest of tan(theta) * 2^11; the 90 degree entry is absent.
package rtan_pkg;

    typedef logic [15:0] coef_t;

    localparam int TAN_N_15 = 7;
    localparam int TAN_N_5  = 19;

    localparam coef_t TAN_TABLE_15 [0:TAN_N_15-2] = '{
        16'd0, 16'd549, 16'd1182, 16'd2048, 16'd3547, 16'd7643
    };

    localparam coef_t TAN_TABLE_5 [0:TAN_N_5-2] = '{
        16'd0,    16'd179,  16'd361,  16'd549,  16'd745,  16'd955,
        16'd1182, 16'd1434, 16'd1718, 16'd2048, 16'd2441, 16'd2925,
        16'd3547, 16'd4392, 16'd5627, 16'd7643, 16'd11615, 16'd23409
    };

    // Anything past the last finite entry (90 degrees or out of range) reads as 0.
    function automatic coef_t tan_coef(input int step, input logic [4:0] idx);
        coef_t c;
        c = '0;
        if (step == 5) begin
            if (idx < 5'd18) c = TAN_TABLE_5[idx];
        end else begin
            if (idx < 5'd6) c = TAN_TABLE_15[idx[2:0]];
        end
        return c;
    endfunction

endpackage

// File: rtl/rtan_stage_reg.sv
// One pipeline slot: valid/data register that loads whenever it is empty or the
// slot downstream is moving, so bubbles are squeezed out even while stalled.
module rtan_stage_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         next_en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         en,
    output logic         valid,
    output logic [W-1:0] data
);

    assign en = !valid || next_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (en) begin
            valid <= in_valid;
            if (in_valid) data <= in_data;
        end
    end

endmodule

// File: rtl/rtan_pipe.sv
// Three-stage r*tan(theta) with symmetric saturation, explicit 90 degree handling
// and a valid/ready handshake on both sides.
module rtan_pipe
    import rtan_pkg::*;
#(
    parameter int IN_W           = 9,
    parameter int OUT_W          = IN_W + 2,
    parameter int ANGLE_STEP_DEG = 15,
    parameter int FRAC_BITS      = 11,
    parameter int IDX_W          = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_r,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_rtan,
    output logic             out_sat,
    output logic             out_err
);

    localparam int PW = IN_W + 17;
    localparam int W1 = IN_W + 18;
    localparam int W2 = PW + 4;
    localparam int W3 = OUT_W + 2;

    localparam logic [IDX_W-1:0]        IDX_90 = IDX_W'(90 / ANGLE_STEP_DEG);
    localparam logic signed [PW-1:0]    MAX_P  = PW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [PW-1:0]    NEG_P  = -MAX_P;
    localparam logic signed [OUT_W-1:0] MAX_O  = OUT_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [OUT_W-1:0] NEG_O  = -MAX_O;

    logic          en1, en2, en3;
    logic          v1, v2, v3;
    logic [W1-1:0] d1, q1;
    logic [W2-1:0] d2, q2;
    logic [W3-1:0] d3, q3;

    // Stage 1: table lookup
    logic  s1_err, s1_inf;
    coef_t s1_coef;

    assign s1_err  = in_idx > IDX_90;
    assign s1_inf  = in_idx == IDX_90;
    assign s1_coef = s1_err ? '0 : tan_coef(ANGLE_STEP_DEG, 5'(in_idx));
    assign d1      = {s1_err, s1_inf, s1_coef, in_r};

    rtan_stage_reg #(.W(W1)) u_s1 (
        .clock(clock), .reset(reset), .next_en(en2), .in_valid(in_valid),
        .in_data(d1), .en(en1), .valid(v1), .data(q1)
    );

    // Stage 2: exact product; coef is unsigned so it gets a zero sign bit
    logic [IN_W-1:0]       r1;
    logic signed [PW-1:0]  r_ext, c_ext, prod;
    logic                  r_pos, r_neg;

    assign r1    = q1[IN_W-1:0];
    assign r_ext = PW'($signed(r1));
    assign c_ext = PW'($signed({1'b0, q1[IN_W +: 16]}));
    assign prod  = r_ext * c_ext;
    assign r_neg = r1[IN_W-1];
    assign r_pos = !r1[IN_W-1] && (r1 != '0);
    assign d2    = {q1[IN_W+17], q1[IN_W+16], r_pos, r_neg, prod};

    rtan_stage_reg #(.W(W2)) u_s2 (
        .clock(clock), .reset(reset), .next_en(en3), .in_valid(v1),
        .in_data(d2), .en(en2), .valid(v2), .data(q2)
    );

    // Stage 3: scale, clamp, special cases
    logic signed [PW-1:0]    p2, shifted;
    logic signed [OUT_W-1:0] rtan_n;
    logic                    sat_n;

    assign p2      = q2[PW-1:0];
    assign shifted = p2 >>> FRAC_BITS;

    always_comb begin
        rtan_n = '0;
        sat_n  = 1'b0;
        if (q2[PW+3]) begin
            rtan_n = '0;
        end else if (q2[PW+2]) begin
            sat_n = 1'b1;
            if (q2[PW+1])   rtan_n = MAX_O;
            else if (q2[PW]) rtan_n = NEG_O;
        end else if (shifted > MAX_P) begin
            rtan_n = MAX_O;
            sat_n  = 1'b1;
        end else if (shifted < NEG_P) begin
            rtan_n = NEG_O;
            sat_n  = 1'b1;
        end else begin
            rtan_n = shifted[OUT_W-1:0];
        end
    end

    assign d3 = {q2[PW+3], sat_n, rtan_n};

    rtan_stage_reg #(.W(W3)) u_s3 (
        .clock(clock), .reset(reset), .next_en(out_ready), .in_valid(v2),
        .in_data(d3), .en(en3), .valid(v3), .data(q3)
    );

    assign in_ready  = en1 && !reset;
    assign out_valid = v3;
    assign out_rtan  = q3[OUT_W-1:0];
    assign out_sat   = q3[OUT_W];
    assign out_err   = q3[OUT_W+1];

endmodule

// File: tb/tb_rtan_pipe.sv
// Scoreboard bench for rtan_pipe: three instances (15 deg/11 bit, 15 deg/10 bit,
// 5 deg/12 bit) share the input bus; one negedge monitor checks all outputs.
module tb_rtan_pipe;

    typedef struct { int r; int idx; int rtan; bit sat; bit err; } vec_t;
    typedef struct { int rtan; bit sat; bit err; int acc; bit lat; } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [8:0]  in_r;
    logic [4:0]  in_idx;

    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat, a_out_err;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat, b_out_err;
    logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_sat, c_out_err;
    logic [10:0] a_out_rtan;
    logic [9:0]  b_out_rtan;
    logic [11:0] c_out_rtan;

    rtan_pipe u_main (
        .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_r(in_r), .in_idx(in_idx), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_rtan(a_out_rtan), .out_sat(a_out_sat), .out_err(a_out_err)
    );

    rtan_pipe #(.OUT_W(10)) u_narrow (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_r(in_r), .in_idx(in_idx), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_rtan(b_out_rtan), .out_sat(b_out_sat), .out_err(b_out_err)
    );

    rtan_pipe #(.OUT_W(12), .ANGLE_STEP_DEG(5)) u_fine (
        .clock(clock), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_r(in_r), .in_idx(in_idx), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_rtan(c_out_rtan), .out_sat(c_out_sat), .out_err(c_out_err)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t sb_c[$];
    vec_t tv_a[16];
    vec_t tv_b[4];
    vec_t tv_c[6];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int r, input int idx, input int rtan, input bit sat, input bit err);
        vec_t v;
        v.r = r; v.idx = idx; v.rtan = rtan; v.sat = sat; v.err = err;
        return v;
    endfunction

    function automatic exp_t to_exp(input vec_t v, input int acc, input bit lat);
        exp_t e;
        e.rtan = v.rtan; e.sat = v.sat; e.err = v.err; e.acc = acc; e.lat = lat;
        return e;
    endfunction

    // Monitor: pop on every output transfer, and check stability during stalls.
    exp_t       e_mon;
    bit         a_hold = 1'b0;
    logic [12:0] a_hold_val;

    always @(negedge clock) begin
        if (reset) begin
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                chk("a_stall_valid", int'(a_out_valid), 1);
                chk("a_stall_rtan", int'({a_out_err, a_out_sat, a_out_rtan}), int'(a_hold_val));
            end
            a_hold     = a_out_valid && !a_out_ready;
            a_hold_val = {a_out_err, a_out_sat, a_out_rtan};
            if (a_out_valid && a_out_ready) begin
                if (sb_a.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected: got rtan %0d, expected no output", $signed(a_out_rtan));
                end else begin
                    e_mon = sb_a.pop_front();
                    chk("a_rtan", $signed(a_out_rtan), e_mon.rtan);
                    chk("a_sat", int'(a_out_sat), int'(e_mon.sat));
                    chk("a_err", int'(a_out_err), int'(e_mon.err));
                    if (e_mon.lat) chk("a_latency", cyc - e_mon.acc, 3);
                end
            end
            if (b_out_valid && b_out_ready) begin
                if (sb_b.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected: got rtan %0d, expected no output", $signed(b_out_rtan));
                end else begin
                    e_mon = sb_b.pop_front();
                    chk("b_rtan", $signed(b_out_rtan), e_mon.rtan);
                    chk("b_sat", int'(b_out_sat), int'(e_mon.sat));
                    chk("b_err", int'(b_out_err), int'(e_mon.err));
                    if (e_mon.lat) chk("b_latency", cyc - e_mon.acc, 3);
                end
            end
            if (c_out_valid && c_out_ready) begin
                if (sb_c.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL c_unexpected: got rtan %0d, expected no output", $signed(c_out_rtan));
                end else begin
                    e_mon = sb_c.pop_front();
                    chk("c_rtan", $signed(c_out_rtan), e_mon.rtan);
                    chk("c_sat", int'(c_out_sat), int'(e_mon.sat));
                    chk("c_err", int'(c_out_err), int'(e_mon.err));
                    if (e_mon.lat) chk("c_latency", cyc - e_mon.acc, 3);
                end
            end
        end
    end

    function automatic bit ready_of(input int sel);
        case (sel)
            0:       return a_in_ready;
            1:       return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    task automatic set_valid(input int sel, input logic v);
        a_in_valid = (sel == 0) ? v : 1'b0;
        b_in_valid = (sel == 1) ? v : 1'b0;
        c_in_valid = (sel == 2) ? v : 1'b0;
    endtask

    task automatic push(input int sel, input exp_t e);
        case (sel)
            0:       sb_a.push_back(e);
            1:       sb_b.push_back(e);
            default: sb_c.push_back(e);
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input int sel, input vec_t v, input bit lat);
        bit done = 1'b0;
        int n = 0;
        in_r   = 9'(v.r);
        in_idx = 5'(v.idx);
        set_valid(sel, 1'b1);
        while (!done && n < 50) begin
            @(negedge clock);
            if (ready_of(sel)) begin
                push(sel, to_exp(v, cyc, lat));
                done = 1'b1;
            end
            @(posedge clock); #1;
            n++;
        end
        set_valid(sel, 1'b0);
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: got no in_ready, expected acceptance within 50 cycles");
        end
    endtask

    task automatic drain();
        int n = 0;
        a_out_ready = 1'b1;
        while ((sb_a.size() + sb_b.size() + sb_c.size()) != 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if ((sb_a.size() + sb_b.size() + sb_c.size()) != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb_a.size() + sb_b.size() + sb_c.size());
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int guard;

        tv_a[0]  = mk( 100,  1,    26, 0, 0);
        tv_a[1]  = mk( 100,  4,   173, 0, 0);
        tv_a[2]  = mk(-100,  1,   -27, 0, 0);
        tv_a[3]  = mk( 255,  5,   951, 0, 0);
        tv_a[4]  = mk(-256,  5,  -956, 0, 0);
        tv_a[5]  = mk(  -3,  6, -1023, 1, 0);
        tv_a[6]  = mk(   0,  6,     0, 1, 0);
        tv_a[7]  = mk(   7,  6,  1023, 1, 0);
        tv_a[8]  = mk(  50,  7,     0, 0, 1);
        tv_a[9]  = mk( 100,  3,   100, 0, 0);
        tv_a[10] = mk(  -1,  1,    -1, 0, 0);
        tv_a[11] = mk(   1,  1,     0, 0, 0);
        tv_a[12] = mk( 200,  5,   746, 0, 0);
        tv_a[13] = mk(-255,  4,  -442, 0, 0);
        tv_a[14] = mk(  -5, 31,     0, 0, 1);
        tv_a[15] = mk(  37,  2,    21, 0, 0);

        tv_b[0] = mk( 200, 5,  511, 1, 0);
        tv_b[1] = mk(-200, 5, -511, 1, 0);
        tv_b[2] = mk( 100, 5,  373, 0, 0);
        tv_b[3] = mk(-256, 6, -511, 1, 0);

        tv_c[0] = mk( 100, 17, 1143, 0, 0);
        tv_c[1] = mk(  -7,  9,   -7, 0, 0);
        tv_c[2] = mk(   5, 18, 2047, 1, 0);
        tv_c[3] = mk(   3, 19,    0, 0, 1);
        tv_c[4] = mk( 255, 17, 2047, 1, 0);
        tv_c[5] = mk( 100,  1,    8, 0, 0);

        reset = 1'b1;
        in_r = '0; in_idx = '0;
        set_valid(0, 1'b0);
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", int'(a_in_ready), 0);
        chk("rst_out_valid", int'(a_out_valid), 0);
        chk("rst_out_rtan", int'(a_out_rtan), 0);
        chk("rst_out_sat", int'(a_out_sat), 0);
        chk("rst_out_err", int'(a_out_err), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed vectors, one per cycle, no backpressure
        for (int i = 0; i < 16; i++) send(0, tv_a[i], 1'b1);
        for (int i = 0; i < 4; i++)  send(1, tv_b[i], 1'b1);
        for (int i = 0; i < 6; i++)  send(2, tv_c[i], 1'b1);
        drain();

        // Stream with random downstream backpressure
        sent = 0;
        guard = 0;
        in_r = 9'(tv_a[0].r);
        in_idx = 5'(tv_a[0].idx);
        set_valid(0, 1'b1);
        while (sent < 20 && guard < 400) begin
            @(negedge clock);
            if (a_in_ready) begin
                sb_a.push_back(to_exp(tv_a[sent % 16], cyc, 1'b0));
                sent++;
            end
            @(posedge clock); #1;
            guard++;
            a_out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                in_r   = 9'(tv_a[sent % 16].r);
                in_idx = 5'(tv_a[sent % 16].idx);
            end else begin
                set_valid(0, 1'b0);
            end
        end
        set_valid(0, 1'b0);
        chk("stream_sent", sent, 20);
        drain();

        // Fill the pipe with downstream stalled, then release a single cycle
        a_out_ready = 1'b0;
        send(0, tv_a[0], 1'b0);
        send(0, tv_a[1], 1'b0);
        send(0, tv_a[2], 1'b0);
        @(negedge clock);
        chk("full_in_ready", int'(a_in_ready), 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("full_in_ready_hold", int'(a_in_ready), 0);
        chk("full_pending", sb_a.size(), 3);
        @(posedge clock); #1;
        a_out_ready = 1'b1;
        @(negedge clock);
        chk("release_in_ready", int'(a_in_ready), 1);
        @(posedge clock); #1;
        a_out_ready = 1'b0;
        @(negedge clock);
        chk("release_one_transfer", sb_a.size(), 2);
        @(posedge clock); #1;
        drain();

        // Reset with two samples in flight
        send(0, tv_a[3], 1'b0);
        send(0, tv_a[4], 1'b0);
        reset = 1'b1;
        sb_a.delete();
        @(negedge clock);
        chk("midrst_in_ready", int'(a_in_ready), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_out_valid", int'(a_out_valid), 0);
        repeat (8) @(posedge clock);
        #1;
        send(0, tv_a[0], 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
